// File: rtl/mic1_main_memory.sv
// Main memory for the MIC-1 datapath: one write port and one registered read port.
// The read port is write-first, and reset clears every word of the array.
module mic1_main_memory #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 9,
    parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wen,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  ren,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rvalid
);

    logic [DATA_WIDTH-1:0] test_memory [0:DEPTH-1];

    logic waddr_ok;
    logic raddr_ok;
    logic bypass;

    // A full-depth array has no out-of-range addresses, so skip the compare.
    generate
        if (DEPTH >= 2 ** ADDR_WIDTH) begin : g_full
            assign waddr_ok = 1'b1;
            assign raddr_ok = 1'b1;
        end else begin : g_partial
            assign waddr_ok = (32'(waddr) < 32'(DEPTH));
            assign raddr_ok = (32'(raddr) < 32'(DEPTH));
        end
    endgenerate

    assign bypass = wen && waddr_ok && (waddr == raddr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                test_memory[i] <= '0;
            end
        end else if (wen && waddr_ok) begin
            test_memory[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata  <= '0;
            rvalid <= 1'b0;
        end else begin
            rvalid <= ren;
            if (ren) begin
                if (!raddr_ok) begin
                    rdata <= '0;
                end else if (bypass) begin
                    rdata <= wdata;
                end else begin
                    rdata <= test_memory[raddr];
                end
            end
        end
    end

endmodule

// File: tb/tb_mic1_main_memory.sv
// Directed bench for mic1_main_memory: hand-computed expectations checked by
// immediate assertions, inputs driven just after the falling edge.
module tb_mic1_main_memory;

    logic       clk;
    logic       rst_n;
    logic       wen;
    logic [8:0] waddr;
    logic [8:0] wdata;
    logic       ren;
    logic [8:0] raddr;
    logic [8:0] rdata;
    logic       rvalid;

    int n_checks = 0;
    int n_pass   = 0;

    mic1_main_memory dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .wen    (wen),
        .waddr  (waddr),
        .wdata  (wdata),
        .ren    (ren),
        .raddr  (raddr),
        .rdata  (rdata),
        .rvalid (rvalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        wen   = 1'b0;
        waddr = '0;
        wdata = '0;
        ren   = 1'b0;
        raddr = '0;

        // Reset held for two cycles, released at a falling edge.
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        for (int i = 0; i <= 10; i++) begin
            check($sformatf("reset_mem[%0d]", i), 32'(dut.test_memory[i]), 32'd0);
        end
        check("reset_rdata", 32'(rdata), 32'd0);
        check("reset_rvalid", 32'(rvalid), 32'd0);
        @(negedge clk);

        // Single write to address 10.
        wen = 1'b1; waddr = 9'd10; wdata = 9'd99;
        tick();
        wen = 1'b0;
        check("wr_mem10", 32'(dut.test_memory[10]), 32'd99);
        for (int i = 0; i <= 9; i++) begin
            check($sformatf("wr_neighbour[%0d]", i), 32'(dut.test_memory[i]), 32'd0);
        end
        check("wr_no_rvalid", 32'(rvalid), 32'd0);

        // Read it back, then idle: rdata holds and rvalid drops.
        ren = 1'b1; raddr = 9'd10;
        tick();
        check("rd10_rdata", 32'(rdata), 32'd99);
        check("rd10_rvalid", 32'(rvalid), 32'd1);
        ren = 1'b0; raddr = 9'd0;
        tick();
        check("idle_rdata_hold", 32'(rdata), 32'd99);
        check("idle_rvalid", 32'(rvalid), 32'd0);

        // Write and read the same address on one edge: write-first.
        wen = 1'b1; waddr = 9'd5; wdata = 9'h1AB;
        ren = 1'b1; raddr = 9'd5;
        tick();
        wen = 1'b0; ren = 1'b0;
        check("wf_rdata", 32'(rdata), 32'h1AB);
        check("wf_rvalid", 32'(rvalid), 32'd1);
        check("wf_mem5", 32'(dut.test_memory[5]), 32'h1AB);

        // Disabled write leaves the array untouched.
        waddr = 9'd3; wdata = 9'd7;
        tick();
        check("nowen_mem3", 32'(dut.test_memory[3]), 32'd0);

        // Independent write and read on one edge; the read sees the old array.
        wen = 1'b1; waddr = 9'd6; wdata = 9'h0F0;
        ren = 1'b1; raddr = 9'd10;
        tick();
        check("indep_rdata", 32'(rdata), 32'd99);
        check("indep_mem6", 32'(dut.test_memory[6]), 32'h0F0);

        // Back-to-back reads with a concurrent write to the top address.
        wen = 1'b1; waddr = 9'd511; wdata = 9'h1FF;
        raddr = 9'd5;
        tick();
        wen = 1'b0;
        check("b2b_rd5", 32'(rdata), 32'h1AB);
        check("b2b_rvalid5", 32'(rvalid), 32'd1);
        raddr = 9'd6;
        tick();
        check("b2b_rd6", 32'(rdata), 32'h0F0);
        raddr = 9'd511;
        tick();
        check("b2b_rd511", 32'(rdata), 32'h1FF);
        check("b2b_rvalid511", 32'(rvalid), 32'd1);
        ren = 1'b0;

        // Write 0x055 to address 20, read it, then reset asynchronously mid-cycle.
        wen = 1'b1; waddr = 9'd20; wdata = 9'h055;
        tick();
        wen = 1'b0;
        ren = 1'b1; raddr = 9'd20;
        tick();
        ren = 1'b0;
        check("pre_rst_mem20", 32'(dut.test_memory[20]), 32'h055);
        check("pre_rst_rdata", 32'(rdata), 32'h055);
        check("pre_rst_rvalid", 32'(rvalid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_mem20", 32'(dut.test_memory[20]), 32'd0);
        check("async_mem5", 32'(dut.test_memory[5]), 32'd0);
        check("async_rdata", 32'(rdata), 32'd0);
        check("async_rvalid", 32'(rvalid), 32'd0);

        // A write and a read presented while reset is held are both lost.
        @(negedge clk);
        wen = 1'b1; waddr = 9'd30; wdata = 9'h123;
        ren = 1'b1; raddr = 9'd30;
        tick();
        check("rst_held_mem30", 32'(dut.test_memory[30]), 32'd0);
        check("rst_held_rvalid", 32'(rvalid), 32'd0);
        wen = 1'b0; ren = 1'b0;
        rst_n = 1'b1;

        // First operation after release is taken normally.
        wen = 1'b1; waddr = 9'd30; wdata = 9'h0AA;
        ren = 1'b1; raddr = 9'd30;
        tick();
        wen = 1'b0; ren = 1'b0;
        check("post_rst_mem30", 32'(dut.test_memory[30]), 32'h0AA);
        check("post_rst_rdata", 32'(rdata), 32'h0AA);
        check("post_rst_rvalid", 32'(rvalid), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
